// File: rtl/delay_line_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delay_line_pkg
// Purpose  : Shared types and width helpers for the multi-channel delay line.
//            - state_t     : delay-line FSM states
//            - ptr_width() : address width of the circular register file
//            - cnt_width() : width able to hold 0..depth inclusive
// Revision : 1.0  initial release
// ============================================================================
package delay_line_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Address width for a register file of 'depth' entries (at least 1 bit).
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_channel_delay_line_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_delay_line_if
// Purpose  : Stream/control bundle of the multi-channel delay line.
//            master : drives clear, cfg_delay, in_valid, in_data, flush
//                     and observes out_valid, out_data, busy, fill_level
//            slave  : the delay line itself (opposite directions)
// Revision : 1.0  initial release
// ============================================================================
interface multi_channel_delay_line_if
  import delay_line_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int MAX_DEPTH  = 64
);
  localparam int W     = CHANNELS * DATA_WIDTH;
  localparam int CNT_W = cnt_width(MAX_DEPTH);

  logic             clear;
  logic [CNT_W-1:0] cfg_delay;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             flush;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             busy;
  logic [CNT_W-1:0] fill_level;

  modport master (
    output clear, cfg_delay, in_valid, in_data, flush,
    input  out_valid, out_data, busy, fill_level
  );

  modport slave (
    input  clear, cfg_delay, in_valid, in_data, flush,
    output out_valid, out_data, busy, fill_level
  );

endinterface
`default_nettype wire

// File: rtl/delay_line_mem.sv
`default_nettype none
// ============================================================================
// Module   : delay_line_mem
// Purpose  : DEPTH x WIDTH register file, one write port and one registered
//            read port. A read and a write to the same address in the same
//            cycle return the old contents (needed when D == MAX_DEPTH).
// Ports    : clk, rst_n (async, active-low, clears storage and read data)
//            we/waddr/wdata  write port
//            re/raddr/rdata  registered read port (rdata holds when re = 0)
// Revision : 1.0  initial release
// ============================================================================
module delay_line_mem #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 24,
  parameter int AW    = 6
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic             re,
  input  wire logic [AW-1:0]    raddr,
  output      logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_channel_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_delay_line
// Purpose  : CHANNELS-wide delay line with runtime delay D (1..MAX_DEPTH),
//            valid-qualified stream, flush/drain and synchronous clear.
//            Storage is a circular register file addressed by wr_ptr; the
//            oldest held sample sits at (wr_ptr - fill_level) mod MAX_DEPTH.
// Ports    : clk, rst_n (async, active-low)
//            bus (slave modport): clear, cfg_delay, in_valid, in_data, flush,
//                                 out_valid, out_data, busy, fill_level
// Revision : 1.0  initial release
// ============================================================================
module multi_channel_delay_line
  import delay_line_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int MAX_DEPTH  = 64
) (
  input wire logic              clk,
  input wire logic              rst_n,
  multi_channel_delay_line_if.slave bus
);

  localparam int W     = CHANNELS * DATA_WIDTH;
  localparam int CNT_W = cnt_width(MAX_DEPTH);
  localparam int PTR_W = ptr_width(MAX_DEPTH);

  state_t           state;
  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] fill_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             out_valid_q;

  logic [CNT_W-1:0] d_eff;
  logic [PTR_W-1:0] head_addr;
  logic [PTR_W-1:0] rd_addr;
  logic             accept;
  logic             do_flush;
  logic             rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Requested delay clamped to 1..MAX_DEPTH.
  always_comb begin
    d_eff = bus.cfg_delay;
    if (bus.cfg_delay == '0)                          d_eff = CNT_W'(1);
    else if (bus.cfg_delay > CNT_W'(MAX_DEPTH))       d_eff = CNT_W'(MAX_DEPTH);
  end

  // Oldest held sample: wr_ptr - fill, wrapped explicitly so non-power-of-2
  // depths work. In RUN fill == D, so this is also the k-D read address.
  // The true result is < MAX_DEPTH, so modular CNT_W arithmetic is exact.
  always_comb begin
    if (CNT_W'(wr_ptr) >= fill_q)
      head_addr = PTR_W'(CNT_W'(wr_ptr) - fill_q);
    else
      head_addr = PTR_W'(CNT_W'(wr_ptr) + CNT_W'(MAX_DEPTH) - fill_q);
  end

  // clear outranks everything; samples arriving while draining are dropped.
  // flush in IDLE is ignored even if a sample arrives in the same cycle.
  assign accept   = bus.in_valid && (state != DRAIN) && !bus.clear;
  assign do_flush = bus.flush && ((state == FILL) || (state == RUN)) && !bus.clear;

  // The first drained sample is read on the flush edge itself, so it is
  // visible the cycle after flush; DRAIN then streams from rd_ptr.
  assign rd_en   = !bus.clear &&
                   ((accept && (state == RUN)) || do_flush ||
                    ((state == DRAIN) && (fill_q != '0)));
  assign rd_addr = (state == DRAIN) ? rd_ptr : head_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      delay_q     <= CNT_W'(1);
      fill_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      state       <= IDLE;
      fill_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      case (state)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (accept) begin
            delay_q <= d_eff;
            fill_q  <= CNT_W'(1);
            state   <= (d_eff == CNT_W'(1)) ? RUN : FILL;
          end
        end
        FILL, RUN: begin
          out_valid_q <= (accept && (state == RUN)) || do_flush;
          if (do_flush) begin
            // Head leaves, an accepted sample joins: net count unchanged.
            state  <= DRAIN;
            rd_ptr <= ptr_inc(head_addr);
            if (!accept) fill_q <= fill_q - CNT_W'(1);
          end else if (accept && (state == FILL)) begin
            fill_q <= fill_q + CNT_W'(1);
            if (fill_q + CNT_W'(1) == delay_q) state <= RUN;
          end
        end
        DRAIN: begin
          // fill_q counts samples not yet presented on out_data.
          if (fill_q != '0) begin
            out_valid_q <= 1'b1;
            rd_ptr      <= ptr_inc(rd_ptr);
            fill_q      <= fill_q - CNT_W'(1);
          end else begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  delay_line_mem #(
    .DEPTH (MAX_DEPTH),
    .WIDTH (W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (bus.in_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (bus.out_data)
  );

  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state == DRAIN);
  assign bus.fill_level = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_delay_line
// Purpose  : Directed self-checking bench for multi_channel_delay_line
//            (DATA_WIDTH 8, CHANNELS 3, MAX_DEPTH 64).
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_channel_delay_line;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multi_channel_delay_line_if #(.DATA_WIDTH(8), .CHANNELS(3), .MAX_DEPTH(64)) bus ();

  multi_channel_delay_line #(.DATA_WIDTH(8), .CHANNELS(3), .MAX_DEPTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Sample k: channel0 = k, channel1 = k+100, channel2 = k+200 (8-bit wrap).
  function automatic logic [23:0] mk(input int k);
    return {8'(k + 200), 8'(k + 100), 8'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [23:0] d,
                            input int fill, input logic bsy);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    if (v) check({tag, ".data"}, 32'(bus.out_data), 32'(d));
    check({tag, ".fill"}, 32'(bus.fill_level), 32'(fill));
    check({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
  endtask

  task automatic drive(input logic v, input logic [23:0] d, input logic fl);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.flush    = fl;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.cfg_delay = '0;
    drive(1'b0, '0, 1'b0);
    repeat (2) tick();
    expect_out("reset", 1'b0, '0, 0, 1'b0);
    check("reset.data", 32'(bus.out_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- D=4, samples 1..10 back-to-back, then drain 7..10 ----
    bus.cfg_delay = 7'd4;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, mk(i), 1'b0);
      tick();
      expect_out($sformatf("d4.s%0d", i), i >= 5, mk(i - 4), (i < 4) ? i : 4, 1'b0);
    end
    drive(1'b0, '0, 1'b0);
    tick();
    expect_out("d4.gap", 1'b0, '0, 4, 1'b0);
    drive(1'b0, '0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      tick();
      bus.flush = 1'b0;
      expect_out($sformatf("d4.drain%0d", j), 1'b1, mk(7 + j), 3 - j, 1'b1);
    end
    tick();
    expect_out("d4.idle", 1'b0, '0, 0, 1'b0);

    // ---- cfg_delay=0 -> D=1, in_valid every other cycle, 0xA0..0xA5 ----
    bus.cfg_delay = 7'd0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, {3{8'(8'hA0 + i)}}, 1'b0);
      tick();
      expect_out($sformatf("d1.acc%0d", i), i > 0, {3{8'(8'hA0 + i - 1)}}, 1, 1'b0);
      drive(1'b0, '0, 1'b0);
      tick();
      expect_out($sformatf("d1.gap%0d", i), 1'b0, '0, 1, 1'b0);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    expect_out("d1.drain", 1'b1, {3{8'hA5}}, 0, 1'b1);
    drive(1'b0, '0, 1'b0);
    tick();
    expect_out("d1.idle", 1'b0, '0, 0, 1'b0);

    // ---- cfg_delay=70 -> D=64, 200 continuous samples, then clear in RUN ----
    bus.cfg_delay = 7'd70;
    for (int k = 0; k < 200; k++) begin
      drive(1'b1, mk(k), 1'b0);
      tick();
      expect_out($sformatf("d64.s%0d", k), k >= 64, mk(k - 64), (k < 63) ? k + 1 : 64, 1'b0);
    end
    drive(1'b0, '0, 1'b0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    expect_out("d64.clear", 1'b0, '0, 0, 1'b0);

    // ---- D=8, 5 samples then flush; in_valid during drain is dropped ----
    bus.cfg_delay = 7'd8;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, mk(i), 1'b0);
      tick();
    end
    expect_out("d8a.fill", 1'b0, '0, 5, 1'b0);
    drive(1'b0, '0, 1'b1);
    tick();
    expect_out("d8a.drain0", 1'b1, mk(1), 4, 1'b1);
    drive(1'b1, mk(99), 1'b0);
    for (int j = 1; j <= 4; j++) begin
      tick();
      expect_out($sformatf("d8a.drain%0d", j), 1'b1, mk(1 + j), 4 - j, 1'b1);
    end
    drive(1'b0, '0, 1'b0);
    tick();
    expect_out("d8a.idle", 1'b0, '0, 0, 1'b0);

    // ---- D=8, flush coincides with the 6th sample -> 6 outputs ----
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, mk(i), 1'b0);
      tick();
    end
    drive(1'b1, mk(6), 1'b1);
    tick();
    expect_out("d8b.drain0", 1'b1, mk(1), 5, 1'b1);
    drive(1'b0, '0, 1'b0);
    for (int j = 1; j <= 5; j++) begin
      tick();
      expect_out($sformatf("d8b.drain%0d", j), 1'b1, mk(1 + j), 5 - j, 1'b1);
    end
    tick();
    expect_out("d8b.idle", 1'b0, '0, 0, 1'b0);

    // ---- D=2: clear mid-drain, restart, then async reset mid-drain ----
    bus.cfg_delay = 7'd2;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, mk(i), 1'b0);
      tick();
    end
    expect_out("d2.run", 1'b1, mk(1), 2, 1'b0);
    drive(1'b0, '0, 1'b1);
    tick();
    expect_out("d2.drain0", 1'b1, mk(2), 1, 1'b1);
    drive(1'b0, '0, 1'b0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    expect_out("d2.clear", 1'b0, '0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(50 + i), 1'b0);
      tick();
      expect_out($sformatf("d2.re%0d", i), i == 2, mk(50), (i == 0) ? 1 : 2, 1'b0);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    expect_out("d2.drainb", 1'b1, mk(51), 1, 1'b1);
    drive(1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expect_out("d2.async_rst", 1'b0, '0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(60 + i), 1'b0);
      tick();
      expect_out($sformatf("d2.rst_re%0d", i), i == 2, mk(60), (i == 0) ? 1 : 2, 1'b0);
    end
    drive(1'b0, '0, 1'b0);
    tick();
    expect_out("d2.stall", 1'b0, '0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
